// File: rtl/preamble_pkg.sv
// Shared types and width helpers for the preamble peak detector.
// Build option PREAMBLE_ZERO_GATE_EN is consumed by the top level.
package preamble_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    REPORT,
    BLANK
  } state_t;

  function automatic int cw_of(input int length);
    return $clog2(length + 1);
  endfunction

  function automatic int unity_scale(input int scaling_bits);
    return 1 << (scaling_bits - 1);
  endfunction

endpackage

// File: rtl/preamble_bank_score.sv
// One correlator bank: masked match count, scaled and
// saturated to the window length.
module preamble_bank_score
  import preamble_pkg::*;
#(
  parameter int LENGTH       = 64,
  parameter int SCALING_BITS = 10,
  localparam int CW          = cw_of(LENGTH)
) (
  input  logic [LENGTH-1:0]       sr,
  input  logic [LENGTH-1:0]       coeff,
  input  logic [CW-1:0]           len,
  input  logic [SCALING_BITS-1:0] scale,
  output logic [CW-1:0]           score
);

  localparam int PW = CW + SCALING_BITS;

  logic [CW-1:0] count;
  logic [PW-1:0] prod;
  logic [PW-1:0] scaled;

  always_comb begin
    count = '0;
    for (int j = 0; j < LENGTH; j++) begin
      if (j < int'(len) && sr[j] == coeff[j]) begin
        count = count + CW'(1);
      end
    end
  end

  assign prod   = PW'(count) * PW'(scale);
  assign scaled = prod >> (SCALING_BITS - 1);

  assign score = (scaled > PW'(LENGTH)) ? CW'(LENGTH)
                                        : scaled[CW-1:0];

endmodule

// File: rtl/preamble_peak_detector.sv
// Multi-bank preamble correlator with windowed peak search and blanking.
// Define PREAMBLE_ZERO_GATE_EN to suppress candidates on carrier-off input.
module preamble_peak_detector
  import preamble_pkg::*;
#(
  parameter int LENGTH       = 64,
  parameter int BANKS        = 16,
  parameter int SCALING_BITS = 10,
  parameter int WINDOW       = 32,
  parameter int BLANK_LEN    = 16,
  localparam int CW = cw_of(LENGTH),
  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int OW = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_dat,
  input  logic                    in_vld,
  input  logic                    cfg_we,
  input  logic [BW-1:0]           cfg_bank,
  input  logic [LENGTH-1:0]       cfg_coeff,
  input  logic [CW-1:0]           cfg_len,
  input  logic [SCALING_BITS-1:0] cfg_scale,
  input  logic [CW-1:0]           cfg_thresh,
  output logic                    det_vld,
  input  logic                    det_rdy,
  output logic [BW-1:0]           det_bank,
  output logic [CW-1:0]           det_score,
  output logic [OW-1:0]           det_offset,
  output logic                    busy
);

  localparam int KW = (BLANK_LEN > 0) ? $clog2(BLANK_LEN + 1) : 1;
  localparam logic [SCALING_BITS-1:0] UNITY =
    SCALING_BITS'(unity_scale(SCALING_BITS));

  logic [LENGTH-1:0]       sr;
  logic [LENGTH-1:0]       sr_next;
  logic                    sc_vld;
  logic [CW-1:0]           raw [BANKS];
  logic [CW-1:0]           sc_score [BANKS];

  logic [LENGTH-1:0]       coeff  [BANKS];
  logic [CW-1:0]           len    [BANKS];
  logic [SCALING_BITS-1:0] scale  [BANKS];
  logic [CW-1:0]           thresh [BANKS];

  logic                    cand_vld;
  logic [BW-1:0]           cand_bank;
  logic [CW-1:0]           cand_score;

  state_t                  state, state_n;
  logic [OW-1:0]           win_cnt, win_n;
  logic [KW-1:0]           blank_cnt, blank_n;
  logic [BW-1:0]           bank_n;
  logic [CW-1:0]           score_n;
  logic [OW-1:0]           off_n;

  // Scores are taken from the post-shift register so sc_vld lags in_vld by 1
  assign sr_next = in_vld ? {sr[LENGTH-2:0], in_dat} : sr;

  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    preamble_bank_score #(
      .LENGTH      (LENGTH),
      .SCALING_BITS(SCALING_BITS)
    ) u_score (
      .sr   (sr_next),
      .coeff(coeff[g]),
      .len  (len[g]),
      .scale(scale[g]),
      .score(raw[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr     <= '0;
      sc_vld <= 1'b0;
      for (int i = 0; i < BANKS; i++) begin
        sc_score[i] <= '0;
      end
    end else begin
      sr     <= sr_next;
      sc_vld <= in_vld;
      if (in_vld) begin
        for (int i = 0; i < BANKS; i++) begin
          sc_score[i] <= raw[i];
        end
      end
    end
  end

`ifdef PREAMBLE_ZERO_GATE_EN
  logic sc_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_zero <= 1'b0;
    end else if (in_vld) begin
      sc_zero <= (sr_next[LENGTH/3:0] == '0);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BANKS; i++) begin
        coeff[i]  <= '0;
        len[i]    <= '0;
        scale[i]  <= UNITY;
        thresh[i] <= '1;
      end
    end else if (cfg_we && !busy) begin
      coeff[cfg_bank]  <= cfg_coeff;
      len[cfg_bank]    <= cfg_len;
      scale[cfg_bank]  <= cfg_scale;
      thresh[cfg_bank] <= cfg_thresh;
    end
  end

  // Ascending scan with strict compare keeps the lowest index on ties
  always_comb begin
    cand_vld   = 1'b0;
    cand_bank  = '0;
    cand_score = '0;
    for (int i = 0; i < BANKS; i++) begin
      if (sc_score[i] >= thresh[i] &&
          (!cand_vld || sc_score[i] > cand_score)) begin
        cand_vld   = 1'b1;
        cand_bank  = BW'(i);
        cand_score = sc_score[i];
      end
    end
`ifdef PREAMBLE_ZERO_GATE_EN
    if (sc_zero) begin
      cand_vld = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      win_cnt    <= '0;
      blank_cnt  <= '0;
      det_bank   <= '0;
      det_score  <= '0;
      det_offset <= '0;
    end else begin
      state      <= state_n;
      win_cnt    <= win_n;
      blank_cnt  <= blank_n;
      det_bank   <= bank_n;
      det_score  <= score_n;
      det_offset <= off_n;
    end
  end

  always_comb begin
    state_n = state;
    win_n   = win_cnt;
    blank_n = blank_cnt;
    bank_n  = det_bank;
    score_n = det_score;
    off_n   = det_offset;
    unique case (state)
      IDLE: begin
        if (sc_vld && cand_vld) begin
          state_n = TRACK;
          bank_n  = cand_bank;
          score_n = cand_score;
          off_n   = '0;
          win_n   = '0;
        end
      end
      TRACK: begin
        if (sc_vld) begin
          win_n = win_cnt + OW'(1);
          if (cand_vld && cand_score > det_score) begin
            bank_n  = cand_bank;
            score_n = cand_score;
            off_n   = win_n;
          end
          if (win_n == OW'(WINDOW - 1)) begin
            state_n = REPORT;
          end
        end
      end
      REPORT: begin
        if (det_rdy) begin
          if (BLANK_LEN == 0) begin
            state_n = IDLE;
          end else begin
            state_n = BLANK;
            blank_n = KW'(BLANK_LEN);
          end
        end
      end
      BLANK: begin
        if (sc_vld) begin
          blank_n = blank_cnt - KW'(1);
          if (blank_cnt == KW'(1)) begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign det_vld = (state == REPORT);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_preamble_peak_detector.sv
// Directed and randomized bench for preamble_peak_detector against a
// sample-level reference model (honours PREAMBLE_ZERO_GATE_EN).
module tb_preamble_peak_detector;

  localparam int L   = 64;
  localparam int NB  = 16;
  localparam int SB  = 10;
  localparam int WIN = 32;
  localparam int BL  = 16;
  localparam int CW  = $clog2(L + 1);
  localparam int BW  = $clog2(NB);
  localparam int OW  = $clog2(WIN);
  localparam int UNI = 1 << (SB - 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_dat = 1'b0;
  logic          in_vld = 1'b0;
  logic          cfg_we = 1'b0;
  logic [BW-1:0] cfg_bank = '0;
  logic [L-1:0]  cfg_coeff = '0;
  logic [CW-1:0] cfg_len = '0;
  logic [SB-1:0] cfg_scale = '0;
  logic [CW-1:0] cfg_thresh = '0;
  logic          det_rdy = 1'b0;
  logic          det_vld;
  logic [BW-1:0] det_bank;
  logic [CW-1:0] det_score;
  logic [OW-1:0] det_offset;
  logic          busy;

  int n_assert = 0;
  int n_fail = 0;

  preamble_peak_detector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_dat    (in_dat),
    .in_vld    (in_vld),
    .cfg_we    (cfg_we),
    .cfg_bank  (cfg_bank),
    .cfg_coeff (cfg_coeff),
    .cfg_len   (cfg_len),
    .cfg_scale (cfg_scale),
    .cfg_thresh(cfg_thresh),
    .det_vld   (det_vld),
    .det_rdy   (det_rdy),
    .det_bank  (det_bank),
    .det_score (det_score),
    .det_offset(det_offset),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: sample history, tables, window of candidates
  logic [L-1:0] m_sr;
  logic [L-1:0] m_coeff [NB];
  int           m_len [NB];
  int           m_scale [NB];
  int           m_thresh [NB];
  int           m_ignore;
  bit           m_open;
  int           wq_bank[$];
  int           wq_score[$];
  bit           exp_det;
  int           exp_bank, exp_score, exp_off;

  function automatic bit m_busy();
    return m_open || exp_det || (m_ignore > 0);
  endfunction

  function automatic int m_score(int b);
    int cnt = 0;
    int s;
    for (int j = 0; j < m_len[b]; j++)
      if (m_sr[j] == m_coeff[b][j]) cnt++;
    s = (cnt * m_scale[b]) / UNI;
    return (s > L) ? L : s;
  endfunction

  task automatic model_reset();
    m_sr = '0;
    for (int b = 0; b < NB; b++) begin
      m_coeff[b] = '0;
      m_len[b] = 0;
      m_scale[b] = UNI;
      m_thresh[b] = (1 << CW) - 1;
    end
    m_ignore = 0;
    m_open = 0;
    wq_bank.delete();
    wq_score.delete();
    exp_det = 0;
  endtask

  task automatic model_cfg(int b, logic [L-1:0] c,
                           int ln, int sc, int th);
    m_coeff[b] = c;
    m_len[b] = ln;
    m_scale[b] = sc;
    m_thresh[b] = th;
  endtask

  task automatic model_push(bit d);
    int cb = -1;
    int cs = -1;
    int s;
    int pk;
    m_sr = {m_sr[L-2:0], d};
    for (int b = 0; b < NB; b++) begin
      s = m_score(b);
      if (s >= m_thresh[b] && s > cs) begin
        cb = b;
        cs = s;
      end
    end
`ifdef PREAMBLE_ZERO_GATE_EN
    if (m_sr[L/3:0] == '0) begin
      cb = -1;
      cs = -1;
    end
`endif
    if (exp_det) begin
    end else if (m_ignore > 0) begin
      m_ignore--;
    end else if (m_open || cb >= 0) begin
      m_open = 1;
      wq_bank.push_back(cb);
      wq_score.push_back(cs);
    end
    if (wq_score.size() == WIN) begin
      pk = 0;
      for (int k = 1; k < WIN; k++)
        if (wq_score[k] > wq_score[pk]) pk = k;
      exp_det = 1;
      exp_bank = wq_bank[pk];
      exp_score = wq_score[pk];
      exp_off = pk;
      wq_bank.delete();
      wq_score.delete();
      m_open = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    chk("det_vld", det_vld, exp_det);
    chk("busy", busy, m_busy());
    if (exp_det) begin
      chk("det_bank", det_bank, exp_bank);
      chk("det_score", det_score, exp_score);
      chk("det_offset", det_offset, exp_off);
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_det_vld", det_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_det_bank", det_bank, 0);
    chk("rst_det_score", det_score, 0);
    chk("rst_det_offset", det_offset, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic cfg(int b, logic [L-1:0] c, int ln, int sc, int th);
    bit ok;
    ok = !m_busy();
    cfg_we = 1'b1;
    cfg_bank = BW'(b);
    cfg_coeff = c;
    cfg_len = CW'(ln);
    cfg_scale = SB'(sc);
    cfg_thresh = CW'(th);
    @(posedge clk);
    #1 cfg_we = 1'b0;
    if (ok) model_cfg(b, c, ln, sc, th);
  endtask

  task automatic push(bit d);
    in_dat = d;
    in_vld = 1'b1;
    @(posedge clk);
    #1 in_vld = 1'b0;
    @(posedge clk);
    #1;
    model_push(d);
    check_state();
  endtask

  // Table write landing in the same cycle as this sample's sc_vld
  task automatic push_cfg(bit d, int b, logic [L-1:0] c,
                          int ln, int sc, int th);
    bit ok;
    ok = !m_busy();
    in_dat = d;
    in_vld = 1'b1;
    @(posedge clk);
    #1 in_vld = 1'b0;
    cfg_we = 1'b1;
    cfg_bank = BW'(b);
    cfg_coeff = c;
    cfg_len = CW'(ln);
    cfg_scale = SB'(sc);
    cfg_thresh = CW'(th);
    @(posedge clk);
    #1 cfg_we = 1'b0;
    model_push(d);
    if (ok) model_cfg(b, c, ln, sc, th);
    check_state();
  endtask

  task automatic push_word(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) push(w[i]);
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) push(1'b0);
  endtask

  task automatic accept(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_state();
    end
    det_rdy = 1'b1;
    @(posedge clk);
    #1 det_rdy = 1'b0;
    exp_det = 0;
    m_ignore = BL;
    check_state();
  endtask

  initial begin
    int bks [4];
    int ln;
    model_reset();
    do_reset();

    // Exact 16-bit pattern, held handshake, blanking boundary
    cfg(3, 64'hA5F0, 16, UNI, 16);
    push_word(16'hA5F0, 16);
    chk("t1_track_busy", busy, 1);
    zeros(WIN - 1);
    chk("t1_vld", det_vld, 1);
    chk("t1_bank", det_bank, 3);
    chk("t1_score", det_score, 16);
    chk("t1_offset", det_offset, 0);
    accept(10);
    push_word(16'hA5F0, 16);
    zeros(WIN);
    chk("t1_blanked_vld", det_vld, 0);
    chk("t1_blanked_busy", busy, 0);
    push_word(16'hA5F0, 16);
    zeros(WIN - 1);
    accept(0);
    push(1'b0);
    push_word(16'hA5F0, 16);
    chk("t1_17th_busy", busy, 1);
    zeros(WIN - 1);
    chk("t1_17th_vld", det_vld, 1);
    accept(0);
    zeros(BL);

    // Later, higher peak wins with its offset
    do_reset();
    cfg(2, 64'hCA71, 16, 416, 12);
    cfg(5, 64'hA716, 16, 480, 12);
    push_word(16'hCA71, 16);
    push_word(16'h0006, 4);
    zeros(WIN - 5);
    chk("t2_vld", det_vld, 1);
    chk("t2_bank", det_bank, 5);
    chk("t2_score", det_score, 15);
    chk("t2_offset", det_offset, 4);
    accept(0);

    // Equal scores go to the lower bank; then reset mid-report
    do_reset();
    cfg(6, 64'hCA71, 16, 448, 14);
    cfg(9, 64'hCA71, 16, 448, 14);
    push_word(16'hCA71, 16);
    zeros(WIN - 1);
    chk("t3_bank", det_bank, 6);
    chk("t3_score", det_score, 14);
    do_reset();
    zeros(WIN);
    chk("t4_no_det_after_rst", det_vld, 0);

    // Writes dropped while busy, honoured on the IDLE->TRACK cycle
    do_reset();
    cfg(3, 64'hA5F0, 16, UNI, 16);
    push_word(16'h52F8, 15);
    push_cfg(1'b0, 8, 64'hCA71, 16, UNI, 16);
    chk("t5_track_busy", busy, 1);
    cfg(7, 64'hCA71, 16, UNI, 16);
    zeros(WIN - 1);
    accept(0);
    zeros(BL);
    push_word(16'hCA71, 16);
    zeros(WIN - 1);
    chk("t5_dropped_bank", det_bank, 8);
    accept(0);
    zeros(BL);
    cfg(7, 64'hCA71, 16, UNI, 16);
    push_word(16'hCA71, 16);
    zeros(WIN - 1);
    chk("t5_applied_bank", det_bank, 7);
    accept(0);

    // All-zero input against all-zero coefficients, saturating scale
    do_reset();
    cfg(0, 64'h0, 64, 1023, 1);
    zeros(WIN);
`ifdef PREAMBLE_ZERO_GATE_EN
    chk("t6_gated_vld", det_vld, 0);
`else
    chk("t6_vld", det_vld, 1);
    chk("t6_score_sat", det_score, 64);
    chk("t6_bank", det_bank, 0);
    accept(0);
`endif

    // Randomized traffic against the model
    do_reset();
    bks[0] = 1;
    bks[1] = 4;
    bks[2] = 11;
    bks[3] = 14;
    for (int k = 0; k < 4; k++) begin
      ln = int'($urandom_range(12, 16));
      cfg(bks[k], L'($urandom_range(0, 65535)), ln,
          int'($urandom_range(460, 620)),
          int'($urandom_range(ln - 5, ln - 2)));
    end
    for (int s = 0; s < 1500; s++) begin
      push(1'($urandom_range(0, 1)));
      if (exp_det) accept(int'($urandom_range(0, 3)));
      if (s % 97 == 96) begin
        ln = int'($urandom_range(12, 16));
        cfg(bks[$urandom_range(0, 3)],
            L'($urandom_range(0, 65535)), ln,
            int'($urandom_range(460, 620)),
            int'($urandom_range(ln - 5, ln - 2)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
